product_accumulator: RTL and testbench

- Downstream consumer of the 4x4 array multiplier's 8-bit product.
- Accumulates a burst of up to COUNT products into one sum, with valid/ready handshakes on both sides.
- A burst ends early when in_last is asserted on an accepted beat.
- Used to build dot products from the combinational multiplier output, registered for the next stage.

---
 rtl/product_accumulator_pkg.sv | 29 ++
 rtl/product_accumulator_acc_add.sv | 31 +++
 rtl/product_accumulator.sv | 112 +++++++++++
 tb/tb_product_accumulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator.
//   - state_e   : two-state burst FSM (ACCUM collects beats, HOLD presents the result)
//   - clog2     : ceiling log2, used to size the beat counter
//   - Def*      : default widths matching the 4x4 array multiplier output
package product_accumulator_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned DefProdW = 8;
    localparam int unsigned DefAccW  = 10;
    localparam int unsigned DefCount = 4;

    // Ceiling log2; clog2(1) == 0 so a COUNT of 1 still gets a 1-bit counter via the +1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/product_accumulator_acc_add.sv
// Ripple-carry adder for the accumulator datapath.
// Ports:
//   a_i     : current accumulator value
//   b_i     : zero-extended incoming product
//   sum_o   : a_i + b_i modulo 2^W
//   carry_o : carry out of the top bit (feeds the sticky overflow flag)
module acc_add #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    // One full adder per bit, carry rippling from LSB to MSB. Kept in a single
    // procedural block so the carry chain is a local variable, not a looping net.
    always_comb begin
        logic carry;
        logic prop;
        carry = 1'b0;
        sum_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            prop     = a_i[i] ^ b_i[i];
            sum_o[i] = prop ^ carry;
            carry    = (a_i[i] & b_i[i]) | (prop & carry);
        end
        carry_o = carry;
    end

endmodule

// File: rtl/product_accumulator.sv
// Product accumulator: sums a burst of up to COUNT unsigned products arriving on a
// valid/ready input and presents the sum, beat count and sticky overflow on a
// valid/ready output. A burst closes after COUNT beats or on an accepted in_last.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_ready is high only while accumulating
//   in_prod              : unsigned product from the multiplier
//   in_last              : closes the burst on an accepted beat
//   out_valid/out_ready  : output handshake; out_valid is high only while holding
//   out_sum              : burst sum modulo 2^ACC_W
//   out_count            : beats in the burst, 1..COUNT
//   out_ovf              : set if any addition in the burst carried out of ACC_W
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = DefProdW,
    parameter int unsigned COUNT  = DefCount,
    parameter int unsigned ACC_W  = DefAccW,
    parameter int unsigned CNT_W  = clog2(COUNT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    if (COUNT < 1) begin : g_bad_count
        $error("product_accumulator: COUNT must be at least 1");
    end
    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("product_accumulator: ACC_W must be at least PROD_W");
    end

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    acc_add #(
        .W (ACC_W)
    ) u_acc_add (
        .a_i     (acc_q),
        .b_i     (ACC_W'(in_prod)),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Handshake outputs are pure state decodes so in_ready never depends on out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);

    // Result outputs come straight from the working registers; they only change in
    // ACCUM, where out_valid is low, so they are stable for the whole HOLD phase.
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_carry;
                    // The closing beat's addition is captured in the same edge.
                    if (in_last || (cnt_q == CNT_W'(COUNT - 1))) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // An in_valid seen here is not taken; in_ready is already low.
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances share all inputs, one with the
// default 10-bit accumulator and one with a 9-bit accumulator so wrap/overflow
// behaviour is exercised alongside the normal case.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_prod;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [9:0] out_sum_a;
    logic [2:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [8:0] out_sum_b;
    logic [2:0] out_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_sum   (out_sum_a),
        .out_count (out_count_a),
        .out_ovf   (out_ovf_a)
    );

    product_accumulator #(
        .ACC_W (9)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_sum   (out_sum_b),
        .out_count (out_count_b),
        .out_ovf   (out_ovf_b)
    );

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] prod;
        logic            last;
        logic [9:0]      sum10;
        logic [8:0]      sum9;
        logic [2:0]      cnt;
        logic            ovf10;
        logic            ovf9;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_prod   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, " out_valid_a"}, 32'(out_valid_a), 32'd0);
        check({name, " out_valid_b"}, 32'(out_valid_b), 32'd0);
        check({name, " in_ready_a"}, 32'(in_ready_a), 32'd1);
        check({name, " in_ready_b"}, 32'(in_ready_b), 32'd1);
    endtask

    task automatic beat(input logic [7:0] prod, input logic last);
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        check("beat in_ready", 32'(in_ready_a & in_ready_b), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input int sum10, input int sum9,
                                 input int cnt, input int ovf10, input int ovf9,
                                 input int hold);
        for (int h = 0; h <= hold; h++) begin
            check({name, " out_valid_a"}, 32'(out_valid_a), 32'd1);
            check({name, " out_valid_b"}, 32'(out_valid_b), 32'd1);
            check({name, " in_ready held low"}, 32'(in_ready_a | in_ready_b), 32'd0);
            check({name, " sum_a"}, 32'(out_sum_a), 32'(sum10));
            check({name, " sum_b"}, 32'(out_sum_b), 32'(sum9));
            check({name, " count_a"}, 32'(out_count_a), 32'(cnt));
            check({name, " count_b"}, 32'(out_count_b), 32'(cnt));
            check({name, " ovf_a"}, 32'(out_ovf_a), 32'(ovf10));
            check({name, " ovf_b"}, 32'(out_ovf_b), 32'(ovf9));
            if (h < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle({name, " release"});
    endtask

    initial begin
        int total;
        int n;
        logic use_last;

        vecs[0] = '{n: 3'd4, prod: {8'd225, 8'd225, 8'd225, 8'd225}, last: 1'b0,
                    sum10: 10'd900, sum9: 9'd388, cnt: 3'd4, ovf10: 1'b0, ovf9: 1'b1};
        vecs[1] = '{n: 3'd3, prod: {8'd0, 8'd7, 8'd5, 8'd3}, last: 1'b1,
                    sum10: 10'd15, sum9: 9'd15, cnt: 3'd3, ovf10: 1'b0, ovf9: 1'b0};
        vecs[2] = '{n: 3'd1, prod: {8'd0, 8'd0, 8'd0, 8'd9}, last: 1'b1,
                    sum10: 10'd9, sum9: 9'd9, cnt: 3'd1, ovf10: 1'b0, ovf9: 1'b0};
        vecs[3] = '{n: 3'd4, prod: {8'd1, 8'd1, 8'd1, 8'd1}, last: 1'b0,
                    sum10: 10'd4, sum9: 9'd4, cnt: 3'd4, ovf10: 1'b0, ovf9: 1'b0};
        vecs[4] = '{n: 3'd4, prod: {8'd255, 8'd255, 8'd255, 8'd255}, last: 1'b0,
                    sum10: 10'd1020, sum9: 9'd508, cnt: 3'd4, ovf10: 1'b0, ovf9: 1'b1};
        vecs[5] = '{n: 3'd2, prod: {8'd0, 8'd0, 8'd200, 8'd200}, last: 1'b1,
                    sum10: 10'd400, sum9: 9'd400, cnt: 3'd2, ovf10: 1'b0, ovf9: 1'b0};
        vecs[6] = '{n: 3'd3, prod: {8'd0, 8'd3, 8'd255, 8'd255}, last: 1'b1,
                    sum10: 10'd513, sum9: 9'd1, cnt: 3'd3, ovf10: 1'b0, ovf9: 1'b1};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset sum_a", 32'(out_sum_a), 32'd0);
        check("reset count_a", 32'(out_count_a), 32'd0);
        check("reset ovf_b", 32'(out_ovf_b), 32'd0);

        // Table of bursts; the first one is held for several cycles to check stability.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                beat(vecs[v].prod[i], vecs[v].last && (i == int'(vecs[v].n) - 1));
            end
            expect_result($sformatf("vec%0d", v), int'(vecs[v].sum10), int'(vecs[v].sum9),
                          int'(vecs[v].cnt), int'(vecs[v].ovf10), int'(vecs[v].ovf9),
                          (v == 0) ? 3 : 1);
        end

        // Gaps in in_valid are skipped; in_last without in_valid must not close the burst.
        beat(8'd10, 1'b0);
        in_prod = 8'd99; in_last = 1'b1; tick(); in_last = 1'b0;
        check("gap1 no close", 32'(out_valid_a), 32'd0);
        beat(8'd20, 1'b0);
        in_prod = 8'd99; in_last = 1'b1; tick(); in_last = 1'b0;
        check("gap2 no close", 32'(out_valid_a), 32'd0);
        beat(8'd30, 1'b0);
        check("after 3 beats", 32'(out_valid_a), 32'd0);
        beat(8'd40, 1'b0);
        expect_result("gaps", 100, 100, 4, 0, 0, 0);

        // in_valid alongside out_ready in HOLD: released, not accepted, taken next cycle.
        beat(8'd7, 1'b1);
        check("hold sum before release", 32'(out_sum_a), 32'd7);
        in_valid = 1'b1; in_prod = 8'd50; in_last = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle("simul release");
        check("simul not accepted", 32'(out_sum_a), 32'd0);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("simul next", 50, 50, 1, 0, 0, 0);

        // Reset mid-burst discards the partial sum.
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle("rst mid");
        check("rst mid sum", 32'(out_sum_a), 32'd0);
        check("rst mid count", 32'(out_count_a), 32'd0);
        for (int i = 0; i < 4; i++) beat(8'd1, 1'b0);
        expect_result("after rst", 4, 4, 4, 0, 0, 0);

        // Reset while holding a result.
        beat(8'd5, 1'b1);
        check("hold before rst", 32'(out_valid_a), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle("rst hold");
        check("rst hold sum", 32'(out_sum_b), 32'd0);

        // Random bursts against an arithmetic model: the result is the plain integer
        // total of the burst, reduced modulo 2^ACC_W, overflow iff total reaches 2^ACC_W.
        for (int b = 0; b < 60; b++) begin
            total    = 0;
            n        = int'($urandom_range(1, 4));
            use_last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    in_valid = 1'b0;
                    in_prod  = 8'($urandom_range(0, 255));
                    in_last  = 1'($urandom_range(0, 1));
                    tick();
                    in_last  = 1'b0;
                    check("rand gap idle", 32'(out_valid_a | out_valid_b), 32'd0);
                end
                in_prod = 8'($urandom_range(0, 255));
                total   = total + int'(in_prod);
                beat(in_prod, use_last && (i == n - 1));
            end
            expect_result($sformatf("rand%0d", b), total % 1024, total % 512, n,
                          (total >= 1024) ? 1 : 0, (total >= 512) ? 1 : 0,
                          int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
